operand_loader: RTL

- Upstream stage of the ALU/display datapath: turns raw board switches and push-buttons into registered operands `a` and `b` and an opcode `sel`.
- The user enters operands one at a time on the shared `data_in` switches, confirming each with the NEXT button.
- After the opcode is entered, the block holds all three values stable and flags them valid for the ALU and display stage.
- Includes button synchronisation, debounce and the entry FSM.

---
 rtl/operand_loader.sv | 127 ++++++++++++
 1 files changed

// File: rtl/operand_loader.sv
// Operand entry front end: synchronises and debounces the NEXT/CLEAR buttons,
// then steps through A, B and opcode capture before presenting them as valid.
module operand_loader #(
    parameter int WIDTH           = 4,
    parameter int SEL_WIDTH       = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 btn_next,
    input  logic                 btn_clear,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic [SEL_WIDTH-1:0] sel,
    output logic [1:0]           load_state,
    output logic                 operands_valid,
    output logic                 start
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    // Bit 0 carries NEXT, bit 1 carries CLEAR through the whole button path.
    logic [1:0]       w_btn;
    logic [1:0]       w_press;
    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_deb;
    logic [1:0]       r_deb_q;
    logic [CNT_W-1:0] r_cnt [2];

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [SEL_WIDTH-1:0] r_sel;
    logic                 r_valid;
    logic                 r_start;

    assign w_btn   = {btn_clear, btn_next};
    assign w_press = r_deb & ~r_deb_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_deb   <= '0;
            r_deb_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1    <= w_btn;
            r_s2    <= r_s1;
            r_deb_q <= r_deb;
            // A level is accepted on the last of DEBOUNCE_CYCLES differing cycles.
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_s2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_start <= 1'b0;
        end else begin
            r_start <= 1'b0;
            if (w_press[1]) begin
                r_state <= S_A;
                r_a     <= '0;
                r_b     <= '0;
                r_sel   <= '0;
                r_valid <= 1'b0;
            end else if (w_press[0]) begin
                case (r_state)
                    S_A: begin
                        r_a     <= data_in;
                        r_state <= S_B;
                        r_valid <= 1'b0;
                    end
                    S_B: begin
                        r_b     <= data_in;
                        r_state <= S_OP;
                        r_valid <= 1'b0;
                    end
                    S_OP: begin
                        r_sel   <= data_in[SEL_WIDTH-1:0];
                        r_state <= S_SHOW;
                        r_valid <= 1'b1;
                        r_start <= 1'b1;
                    end
                    default: begin
                        r_state <= S_A;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign a              = r_a;
    assign b              = r_b;
    assign sel            = r_sel;
    assign load_state     = r_state;
    assign operands_valid = r_valid;
    assign start          = r_start;

endmodule
